// File: rtl/round_robin_collector_pkg.sv
// Shared definitions for the round-robin collector: station indices,
// output-register state encoding and a one-hot to index helper.
package collector_pkg;

    localparam logic [1:0] LIB    = 2'd0;
    localparam logic [1:0] FIRE   = 2'd1;
    localparam logic [1:0] SCHOOL = 2'd2;
    localparam logic [1:0] SHACK  = 2'd3;

    localparam int unsigned NSTATIONS = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NSTATIONS; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/round_robin_collector_if.sv
// Station-side and downstream-side handshake bundle of the collector.
// The collector uses the slave view; whatever drives the stations uses master.
interface round_robin_collector_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic [WIDTH-1:0] lib;
    logic [WIDTH-1:0] fire;
    logic [WIDTH-1:0] school;
    logic [WIDTH-1:0] shack;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [WIDTH-1:0] dataOut;
    logic [1:0]       sel;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output enable, lib, fire, school, shack, in_valid, out_ready,
        input  in_ready, dataOut, sel, out_valid
    );

    modport slave (
        input  enable, lib, fire, school, shack, in_valid, out_ready,
        output in_ready, dataOut, sel, out_valid
    );
endinterface

// File: rtl/round_robin_collector_arb.sv
// Four-way round-robin grant: first requester at or after ptr, wrapping 3->0.
module rr_arbiter4
    import collector_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    input  logic       en,
    output logic [3:0] grant
);

    logic [1:0] idx;

    always_comb begin
        grant = '0;
        idx   = '0;
        if (en) begin
            for (int unsigned k = 0; k < NSTATIONS; k++) begin
                idx = ptr + 2'(k);
                if (req[idx] && (grant == 4'b0000)) grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/round_robin_collector.sv
// Collects words from four stations in round-robin order into a
// single-entry output register with a valid/ready downstream handshake.
module round_robin_collector
    import collector_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    round_robin_collector_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       ptr;
    logic [1:0]       gidx;
    logic [3:0]       grant;
    logic             arb_en;
    logic             load;
    logic [WIDTH-1:0] word;

    // Reset gates the arbiter so in_ready is quiet while reset is held.
    assign arb_en = !reset && bus.enable && ((state == EMPTY) || bus.out_ready);

    rr_arbiter4 u_arb (
        .req   (bus.in_valid),
        .ptr   (ptr),
        .en    (arb_en),
        .grant (grant)
    );

    assign load         = |grant;
    assign gidx         = onehot_to_idx(grant);
    assign bus.in_ready = grant;
    assign bus.out_valid = (state == FULL);

    always_comb begin
        word = bus.lib;
        case (gidx)
            LIB:     word = bus.lib;
            FIRE:    word = bus.fire;
            SCHOOL:  word = bus.school;
            SHACK:   word = bus.shack;
            default: word = bus.lib;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (load) state_nxt = FULL;
            FULL:    if (!load && bus.out_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            ptr         <= '0;
            bus.dataOut <= '0;
            bus.sel     <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                bus.dataOut <= word;
                bus.sel     <= gidx;
                ptr         <= gidx + 2'd1;
            end
        end
    end

endmodule

// File: doc/round_robin_collector.md
ROUND_ROBIN_COLLECTOR -- requirements
Module: round_robin_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width of every channel and of the output.
REQ-002 The block SHALL have clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have enable  input  1  high permits new words to be accepted; low blocks acceptance only.
REQ-005 The block SHALL have lib, fire, school, shack  input  WIDTH each  per-station source data.
REQ-006 The block SHALL have in_valid  input  4  per-station valid; bit 0=lib, 1=fire, 2=school, 3=shack.
REQ-007 The block SHALL have in_ready  output  4  per-station ready, same bit order; combinational from state and inputs.
REQ-008 The block SHALL have dataOut  output  WIDTH  the registered selected word.
REQ-009 The block SHALL have sel  output  2  the registered index of the station that supplied dataOut.
REQ-010 The block SHALL have out_valid  output  1  dataOut/sel hold a word not yet accepted downstream.
REQ-011 The block SHALL have out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.

Function
REQ-012 The block SHALL hold a single-entry output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 The load condition SHALL be: enable=1, in_valid!=0, and (state EMPTY, or state FULL with out_ready=1).
REQ-014 When the load condition holds, exactly one in_ready bit SHALL be high: the first requesting station at or after pointer ptr, searching ptr, ptr+1, ... with wrap from 3 to 0; otherwise in_ready SHALL be 0000.
REQ-015 On a load, the granted station's data SHALL be registered into dataOut, its index into sel, and out_valid SHALL be 1 on the next cycle (latency one cycle).
REQ-016 On a load granting station i, ptr SHALL become (i+1) mod 4; otherwise ptr SHALL be unchanged.
REQ-017 Transitions: EMPTY->FULL on load; FULL->EMPTY on out_ready=1 with no load; FULL->FULL on load with out_ready=1 (back-to-back) or on out_ready=0 (stall).
REQ-018 During a stall (FULL, out_ready=0), dataOut, sel and out_valid SHALL stay stable and in_ready SHALL be 0000.
REQ-019 With out_ready held high and requests continuous, the block SHALL accept one word per cycle.
REQ-020 enable=0 SHALL NOT discard a pending word; a FULL register SHALL still drain on out_ready=1, then go EMPTY.
REQ-021 A station whose in_valid is high but not granted SHALL be served within 4 loads (starvation-free).
REQ-022 dataOut and sel SHALL retain their last values when EMPTY.

Reset
REQ-023 With reset=1 at a clock edge: out_valid=0, dataOut=0, sel=0, ptr=0, state EMPTY.
REQ-024 While reset=1, in_ready SHALL be 0000 regardless of other inputs.
REQ-025 Reset asserted while FULL SHALL discard the pending word; it SHALL never be presented after reset.

Structure
REQ-026 A shared package collector_pkg SHALL hold station index constants LIB=0, FIRE=1, SCHOOL=2, SHACK=3 and the EMPTY/FULL state encoding.
REQ-027 The round-robin grant logic SHALL be a sub-module rr_arbiter4 (inputs req[3:0], ptr[1:0], en; output one-hot grant[3:0]).

Verification
REQ-028 Reset, then lib=4'hA valid alone, out_ready=1 -> in_ready=0001 same cycle; next cycle dataOut=4'hA, sel=0, out_valid=1; ptr=1.
REQ-029 All four valid (lib=1, fire=2, school=3, shack=4), out_ready=1 for 5 cycles -> dataOut sequence 1,2,3,4,1 with sel 0,1,2,3,0 on consecutive cycles.
REQ-030 Load school=4'h5, then out_ready=0 for 3 cycles with all in_valid=1 -> dataOut=5, sel=2 held, in_ready=0000; on out_ready=1, shack word loaded next.
REQ-031 FULL with fire=4'h7 pending, enable=0, out_ready=1 -> word accepted, out_valid=0 next cycle, in_ready stays 0000 while enable=0.
REQ-032 Reset asserted for one cycle while FULL with shack pending -> out_valid=0, dataOut=0, sel=0 next cycle; next load with all valid grants lib.
